// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - request/response handshake bundle for multicycle_alu
// Purpose: groups the request (in_*), response (out_*) and result signals of the ALU.
// Ports (signals):
//   in_valid, in_ready         request handshake
//   in1, in2 [WIDTH]           operands
//   alu_control [4]            operation code
//   out_valid, out_ready       response handshake
//   alu_result [WIDTH]         result
//   zero_flag, illegal_op      result flags
// Modports: master = requester/consumer side, slave = the ALU.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero_flag;
  logic             illegal_op;

  modport master (
    output in_valid, in1, in2, alu_control, out_ready,
    input  in_ready, out_valid, alu_result, zero_flag, illegal_op
  );

  modport slave (
    input  in_valid, in1, in2, alu_control, out_ready,
    output in_ready, out_valid, alu_result, zero_flag, illegal_op
  );
endinterface

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - handshaked execute-stage ALU with iterative multiply and optional divide
// Purpose: single-cycle logic/add/shift/compare ops, WIDTH-iteration shift-add multiply and,
//   when MULTICYCLE_ALU_DIV_EN is defined, WIDTH-iteration restoring unsigned divide/remainder.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    multicycle_alu_if.slave: in_valid/in_ready/in1/in2/alu_control request,
//          out_valid/out_ready/alu_result/zero_flag/illegal_op response
// Parameters: WIDTH (power of 2, >= 8); must match the WIDTH of the connected interface.
// Macro: MULTICYCLE_ALU_DIV_EN enables codes 1100 DIVU and 1101 REMU.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next_state;

  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] opa, opb, acc;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, illegal_q;

  logic             accept, multi_op, last_iter;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_result;
  logic             sc_illegal;
  logic [WIDTH-1:0] step_acc, step_opa, step_opb, mc_result;

  assign accept    = bus.in_valid && (state == IDLE);
  assign last_iter = (cnt == SHW'(WIDTH - 1));
  assign shamt     = bus.in2[SHW-1:0];

`ifdef MULTICYCLE_ALU_DIV_EN
  assign multi_op = (bus.alu_control == OP_MUL) || (bus.alu_control == OP_DIVU) ||
                    (bus.alu_control == OP_REMU);
`else
  assign multi_op = (bus.alu_control == OP_MUL);
`endif

  // Single-cycle ops are evaluated straight off the request so the result can be
  // registered on the accept edge itself.
  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (bus.alu_control)
      OP_AND:  sc_result = bus.in1 & bus.in2;
      OP_OR:   sc_result = bus.in1 | bus.in2;
      OP_ADD:  sc_result = bus.in1 + bus.in2;
      OP_SUB:  sc_result = bus.in1 - bus.in2;
      OP_XOR:  sc_result = bus.in1 ^ bus.in2;
      OP_SLL:  sc_result = bus.in1 << shamt;
      OP_SRL:  sc_result = bus.in1 >> shamt;
      OP_SRA:  sc_result = $unsigned($signed(bus.in1) >>> shamt);
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
      default: sc_illegal = 1'b1;
    endcase
  end

  // One iteration of the multi-cycle datapath.
  // MUL: acc = partial product, opa = shifted multiplicand, opb = remaining multiplier bits.
  // DIV: acc = partial remainder, opa = divisor, opb = dividend shifting out / quotient shifting in.
`ifdef MULTICYCLE_ALU_DIV_EN
  logic [WIDTH:0] div_trial;
  assign div_trial = {acc, opb[WIDTH-1]};
`endif

  always_comb begin
    step_acc  = acc + (opb[0] ? opa : '0);
    step_opa  = opa << 1;
    step_opb  = opb >> 1;
    mc_result = step_acc;
`ifdef MULTICYCLE_ALU_DIV_EN
    if (op_q != OP_MUL) begin
      step_opa = opa;
      if (div_trial >= {1'b0, opa}) begin
        step_acc = div_trial[WIDTH-1:0] - opa;
        step_opb = {opb[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = div_trial[WIDTH-1:0];
        step_opb = {opb[WIDTH-2:0], 1'b0};
      end
      mc_result = (op_q == OP_DIVU) ? step_opb : step_acc;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = multi_op ? BUSY : DONE;
      BUSY:    if (last_iter) next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.out_valid  = (state == DONE);
    bus.alu_result = result_q;
    bus.zero_flag  = zero_q;
    bus.illegal_op = illegal_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= bus.alu_control;
            cnt  <= '0;
            acc  <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            if (bus.alu_control != OP_MUL) begin
              opa <= bus.in2;
              opb <= bus.in1;
            end else begin
              opa <= bus.in1;
              opb <= bus.in2;
            end
`else
            opa <= bus.in1;
            opb <= bus.in2;
`endif
            if (!multi_op) begin
              result_q  <= sc_result;
              zero_q    <= (sc_result == '0);
              illegal_q <= sc_illegal;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + SHW'(1);
          acc <= step_acc;
          opa <= step_opa;
          opb <= step_opb;
          if (last_iter) begin
            result_q  <= mc_result;
            zero_q    <= (mc_result == '0);
            illegal_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
